// File: rtl/scrambler_par_if.sv
// scrambler_par_if: valid/ready word stream between scrambler stages.
//   data  : DW-bit word, bit 0 processed first
//   valid : producer has a word
//   ready : consumer can take it
//   sof   : frame start marker (only with SCRAMBLER_FRAME_RESEED_EN)
// Modports: master drives data/valid(/sof), slave drives ready.
// Macro: SCRAMBLER_FRAME_RESEED_EN adds the sof signal.
interface scrambler_par_if #(
  parameter int DW = 8
);
  logic [DW-1:0] data;
  logic          valid;
  logic          ready;
`ifdef SCRAMBLER_FRAME_RESEED_EN
  logic          sof;
  modport master (output data, output valid, output sof, input ready);
  modport slave  (input data, input valid, input sof, output ready);
`else
  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
`endif
endinterface

// File: rtl/scrambler_par.sv
// scrambler_par: DW-bit-per-cycle LFSR scrambler / descrambler.
//   MODE 0 additive, 1 self-sync scramble, 2 self-sync descramble (3 -> 0).
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_load/i_seed  load LFSR from seed (blocks input that cycle)
//   s              slave stream in  (scrambler_par_if.slave)
//   m              master stream out (scrambler_par_if.master), 1-cycle latency
//   o_lfsr_zero    registered: LFSR state is all-zero
// Macro: SCRAMBLER_FRAME_RESEED_EN -> s.sof reseeds from i_seed for that beat;
//   the marker is forwarded on m.sof so a downstream stage sees frame starts.
module scrambler_par #(
  parameter int                LFSR_W   = 7,
  parameter logic [LFSR_W-1:0] TAPS     = 7'b1001000,
  parameter int                DW       = 8,
  parameter int                MODE     = 0,
  parameter logic [LFSR_W-1:0] RST_SEED = 7'h7F
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic [LFSR_W-1:0] i_seed,
  scrambler_par_if.slave    s,
  scrambler_par_if.master   m,
  output logic              o_lfsr_zero
);

  logic [LFSR_W-1:0] r_lfsr;
  logic [DW-1:0]     r_mdata;
  logic              r_mvalid;
  logic              r_zero;

  logic [LFSR_W-1:0] w_start;
  logic [LFSR_W-1:0] w_st;
  logic [LFSR_W-1:0] w_lfsr_nxt;
  logic [DW-1:0]     w_out;
  logic              w_fb;
  logic              w_sh;
  logic              w_acc;

  // single output register, no skid: take a word only if the slot frees now
  assign s.ready = !i_load && (!r_mvalid || m.ready);
  assign w_acc   = s.valid && s.ready;

`ifdef SCRAMBLER_FRAME_RESEED_EN
  logic r_msof;
  assign w_start = s.sof ? i_seed : r_lfsr;
  assign m.sof   = r_msof;
`else
  assign w_start = r_lfsr;
`endif

  // DW serial LFSR steps unrolled; bit 0 sees the oldest state
  always_comb begin
    w_st  = w_start;
    w_out = '0;
    w_fb  = 1'b0;
    w_sh  = 1'b0;
    for (int k = 0; k < DW; k++) begin
      w_fb     = ^(w_st & TAPS);
      w_out[k] = s.data[k] ^ w_fb;
      if (MODE == 1)      w_sh = w_out[k];   // feed back scrambled bit
      else if (MODE == 2) w_sh = s.data[k];  // feed back received bit
      else                w_sh = w_fb;       // free-running keystream
      w_st = {w_st[LFSR_W-2:0], w_sh};
    end
  end

  always_comb begin
    w_lfsr_nxt = r_lfsr;
    if (i_load)     w_lfsr_nxt = i_seed;
    else if (w_acc) w_lfsr_nxt = w_st;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lfsr   <= RST_SEED;
      r_mdata  <= '0;
      r_mvalid <= 1'b0;
      r_zero   <= (RST_SEED == '0);
    end else begin
      r_lfsr <= w_lfsr_nxt;
      r_zero <= (w_lfsr_nxt == '0);
      if (w_acc) begin
        r_mdata  <= w_out;
        r_mvalid <= 1'b1;
      end else if (m.ready) begin
        r_mvalid <= 1'b0;
      end
    end
  end

`ifdef SCRAMBLER_FRAME_RESEED_EN
  always_ff @(posedge i_clk) begin
    if (i_rst)      r_msof <= 1'b0;
    else if (w_acc) r_msof <= s.sof;
  end
`endif

  assign m.data      = r_mdata;
  assign m.valid     = r_mvalid;
  assign o_lfsr_zero = r_zero;

endmodule
